ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the operands, funct3 and destination register from the ID/EX pipeline register. It holds the pipeline stalled through the hazard unit while it iterates, then presents a 32-bit result for one cycle so the instruction can advance into EX/MEM.

---
 rtl/ex_muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32-cycle shift-add multiply
// and restoring divide, stalling the pipeline via busy and pulsing done with the result.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  func_q, func_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    logic        accept, is_div, a_signed, b_signed, sign_a, sign_b;
    logic        div_zero, overflow, special;
    logic [31:0] abs_a, abs_b, special_res;
    logic [32:0] mul_sum, rem_sh;
    logic        rem_ge;
    logic [31:0] rem_nx, rem_fix, final_res;
    logic [63:0] step, prod_fix;

    assign accept = (state_q == S_IDLE) && start && !flush;

    // Operand decode at accept time: absolute values, result sign, special cases.
    always_comb begin
        is_div   = funct3[2];
        a_signed = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed = funct3 inside {3'b001, 3'b100, 3'b110};
        sign_a   = a_signed && op_a[31];
        sign_b   = b_signed && op_b[31];
        abs_a    = sign_a ? (32'd0 - op_a) : op_a;
        abs_b    = sign_b ? (32'd0 - op_b) : op_b;
        div_zero = is_div && (op_b == 32'd0);
        overflow = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        special  = div_zero || overflow;
        if (div_zero) special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration. Multiply keeps {partial_hi, multiplier} in acc; divide keeps
    // {remainder, dividend/quotient}. opnd_q is the multiplicand or the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        rem_sh    = acc_q[63:31];
        rem_ge    = rem_sh >= {1'b0, opnd_q};
        rem_nx    = rem_ge ? (rem_sh[31:0] - opnd_q) : rem_sh[31:0];
        step      = func_q[2] ? {rem_nx, acc_q[30:0], rem_ge} : {mul_sum, acc_q[31:1]};
        prod_fix  = neg_q ? (64'd0 - step) : step;
        rem_fix   = neg_q ? (32'd0 - step[63:32]) : step[63:32];
        case (func_q)
            3'b000, 3'b100, 3'b101: final_res = prod_fix[31:0];
            3'b110, 3'b111:         final_res = rem_fix;
            default:                final_res = prod_fix[63:32];
        endcase
    end

    // NOTE: state_q lives in its own flop process; all flops use non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush wins over start and over completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == 6'd31) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        func_d   = func_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (accept) begin
            cnt_d  = 6'd0;
            func_d = funct3;
            rd_d   = rd_in;
            opnd_d = is_div ? abs_b : abs_a;
            acc_d  = {32'd0, is_div ? abs_a : abs_b};
            neg_d  = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
            if (special) result_d = special_res;
        end else if (state_q == S_CALC && !flush) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = step;
            if (cnt_q == 6'd31) result_d = final_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 6'd0;
            func_q   <= 3'd0;
            rd_q     <= 5'd0;
            opnd_q   <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            func_q   <= func_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Outputs: busy is combinational on start so the accepting cycle already stalls.
    always_comb begin
        busy = accept || (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: expected results go into a
// scoreboard queue when an operation is issued and are checked when done pulses.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    ex_muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new instruction into EX at the next falling edge.
    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
    endtask

    // Issue one operation, wait (bounded) for done, then check latency and scoreboard.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int lat);
        int   n;
        logic busy_gap;
        exp_t e;
        drive(f, a, b, rd);
        sb.push_back('{rd: rd, res: exp_res});
        #1 check({tag, "_busy_accept"}, busy, 1'b1);
        n        = 0;
        busy_gap = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!done && !busy) busy_gap = 1'b1;
        end while (!done && n < 100);
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_gap"}, busy_gap, 1'b0);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        e = sb.pop_front();
        check({tag, "_result"}, result, e.res);
        check({tag, "_rd_out"}, rd_out, e.rd);
    endtask

    task automatic go_idle();
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic        seen_done;
        logic [31:0] prev_res;

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        rd_in  = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", rd_out, 5'd0);
        reset = 1'b0;

        // Multiplies
        run_op("mul_7x6",      MUL,    32'd7,          32'd6,          5'd5,  32'h0000_002A, 33);
        run_op("mulh_m1xm1",   MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000, 33);
        run_op("mulhu_m1xm1",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE, 33);
        run_op("mulhsu_m1x2",  MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF, 33);
        run_op("mulh_m7x6",    MULH,   32'hFFFF_FFF9,  32'd6,          5'd9,  32'hFFFF_FFFF, 33);
        run_op("mul_wrap",     MUL,    32'h0001_0000,  32'h0001_0000,  5'd10, 32'h0000_0000, 33);
        run_op("mulhu_wrap",   MULHU,  32'h0001_0000,  32'h0001_0000,  5'd11, 32'h0000_0001, 33);

        // Divides
        run_op("div_m7_2",     DIV,    32'hFFFF_FFF9,  32'd2,          5'd12, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",     REM,    32'hFFFF_FFF9,  32'd2,          5'd13, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7",   DIVU,   32'd100,        32'd7,          5'd14, 32'd14,        33);
        run_op("remu_100_7",   REMU,   32'd100,        32'd7,          5'd15, 32'd2,         33);

        // Special cases finish the cycle after accept
        run_op("div_by0",      DIV,    32'd5,          32'd0,          5'd16, 32'hFFFF_FFFF, 1);
        run_op("remu_by0",     REMU,   32'd5,          32'd0,          5'd17, 32'd5,         1);
        run_op("div_ovf",      DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'h8000_0000, 1);
        run_op("rem_ovf",      REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 32'd0,         1);
        run_op("rem_7_m2",     REM,    32'd7,          32'hFFFF_FFFE,  5'd20, 32'd1,         33);
        prev_res = 32'd1;
        go_idle();

        // Flush at T+10 of a DIVU: no done, result untouched, restart at T+12
        drive(DIVU, 32'd1000, 32'd10, 5'd21);
        seen_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) seen_done = 1'b1;
        check("flush_busy", busy, 1'b0);
        check("flush_no_done", seen_done, 1'b0);
        check("flush_result_held", result, prev_res);
        run_op("divu_after_flush", DIVU, 32'd1000, 32'd10, 5'd22, 32'd100, 33);
        go_idle();

        // Reset in the middle of a multiply aborts it immediately
        drive(MUL, 32'd3, 32'd3, 5'd23);
        repeat (5) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_out", rd_out, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back operations after reset
        run_op("b2b_mul_9x9",  MUL,    32'd9,          32'd9,          5'd24, 32'h0000_0051, 33);
        run_op("b2b_div_m100", DIV,    32'hFFFF_FF9C,  32'd7,          5'd25, 32'hFFFF_FFF2, 33);
        run_op("b2b_mul_ffff", MUL,    32'h0000_FFFF,  32'h0000_FFFF,  5'd26, 32'hFFFE_0001, 33);
        run_op("b2b_divu_max", DIVU,   32'hFFFF_FFFF,  32'd1,          5'd27, 32'hFFFF_FFFF, 33);
        go_idle();
        @(negedge clk);
        check("idle_no_done", done, 1'b0);
        check("idle_result_held", result, 32'hFFFF_FFFF);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
